// File: rtl/fco_align_status_tx.sv
// rtl/fco_align_status_tx.sv - FCO bitslip alignment engine with 4-phase status return to the control domain
// Optional build macro FCO_LOSS_FILTER_EN: in LOCKED, loss needs two consecutive mismatches.
module fco_align_status_tx #(
    parameter logic [7:0] FCO_PATTERN = 8'hF0,
    parameter int         SLIP_WAIT   = 4,
    parameter int         LOCK_CNT    = 16,
    parameter int         MAX_SLIPS   = 8
) (
    input  logic        clk_dco_fc,
    input  logic        reset,
    input  logic [7:0]  fco_word,
    input  logic        align_en,
    output logic        bitslip,
    output logic        aligned,
    output logic        status_req,
    output logic [15:0] status_data,
    input  logic        status_ack
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SLIP   = 3'd2,
        S_WAIT   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] match_cnt, match_cnt_nxt;
    logic [3:0]    slip_cnt, slip_cnt_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic [6:0]    loss_cnt, loss_cnt_nxt;
    logic          evt_nxt;
    logic          match;
    logic          loss_hit;
    logic          ack_meta, ack_s;
    logic          pending;
    logic          capture;
    logic [15:0]   snapshot;

    assign match = (fco_word == FCO_PATTERN);

`ifdef FCO_LOSS_FILTER_EN
    // Remembers one isolated mismatch while locked; a second in a row declares loss.
    logic miss_seen;
    always_ff @(posedge clk_dco_fc or posedge reset) begin
        if (reset) begin
            miss_seen <= 1'b0;
        end else begin
            miss_seen <= align_en && (state == S_LOCKED) && !match && !miss_seen;
        end
    end
    assign loss_hit = !match && miss_seen;
`else
    assign loss_hit = !match;
`endif

    always_ff @(posedge clk_dco_fc or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            match_cnt <= '0;
            slip_cnt  <= '0;
            wait_cnt  <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_cnt_nxt;
            slip_cnt  <= slip_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            loss_cnt  <= loss_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        slip_cnt_nxt  = slip_cnt;
        wait_cnt_nxt  = wait_cnt;
        loss_cnt_nxt  = loss_cnt;
        evt_nxt       = 1'b0;
        if (!align_en) begin
            // loss_cnt survives disable so the control side keeps the history
            state_nxt     = S_IDLE;
            match_cnt_nxt = '0;
            slip_cnt_nxt  = '0;
            wait_cnt_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    match_cnt_nxt = '0;
                    slip_cnt_nxt  = '0;
                    wait_cnt_nxt  = '0;
                    state_nxt     = S_CHECK;
                end
                S_CHECK: begin
                    if (match) begin
                        match_cnt_nxt = match_cnt + MW'(1);
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state_nxt = S_LOCKED;
                            evt_nxt   = 1'b1;
                        end
                    end else if (slip_cnt == 4'(MAX_SLIPS)) begin
                        state_nxt = S_FAIL;
                        evt_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_SLIP;
                    end
                end
                S_SLIP: begin
                    slip_cnt_nxt = slip_cnt + 4'd1;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
                        match_cnt_nxt = '0;
                        state_nxt     = S_CHECK;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WW'(1);
                    end
                end
                S_LOCKED: begin
                    if (loss_hit) begin
                        if (loss_cnt != 7'd127) begin
                            loss_cnt_nxt = loss_cnt + 7'd1;
                        end
                        slip_cnt_nxt  = '0;
                        match_cnt_nxt = '0;
                        evt_nxt       = 1'b1;
                        state_nxt     = S_CHECK;
                    end
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bitslip = (state == S_SLIP);
        aligned = (state == S_LOCKED);
    end

    always_ff @(posedge clk_dco_fc or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= status_ack;
            ack_s    <= ack_meta;
        end
    end

    assign snapshot = {aligned, (state == S_FAIL), 3'(state), slip_cnt, loss_cnt};
    assign capture  = pending && !status_req && !ack_s;

    // Events arriving while a transfer is busy fold into one pending flag.
    always_ff @(posedge clk_dco_fc or posedge reset) begin
        if (reset) begin
            pending     <= 1'b0;
            status_req  <= 1'b0;
            status_data <= '0;
        end else begin
            pending <= evt_nxt || (pending && !capture);
            if (capture) begin
                status_req  <= 1'b1;
                status_data <= snapshot;
            end else if (status_req && ack_s) begin
                status_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fco_align_status_tx.sv
// tb/tb_fco_align_status_tx.sv - self-checking bench for fco_align_status_tx
`timescale 1ns/1ps
module tb_fco_align_status_tx;
    localparam int SLIP_WAIT = 4;
    localparam int LOCK_CNT  = 16;
    localparam int MAX_SLIPS = 8;
`ifdef FCO_LOSS_FILTER_EN
    localparam int GLEN = 2;
`else
    localparam int GLEN = 1;
`endif

    logic        clk_dco_fc = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  fco_word = 8'hF0;
    logic        align_en = 1'b0;
    logic        status_ack = 1'b0;
    logic        bitslip, aligned, status_req;
    logic [15:0] status_data;

    fco_align_status_tx #(
        .FCO_PATTERN(8'hF0), .SLIP_WAIT(SLIP_WAIT), .LOCK_CNT(LOCK_CNT), .MAX_SLIPS(MAX_SLIPS)
    ) dut (
        .clk_dco_fc(clk_dco_fc), .reset(reset), .fco_word(fco_word), .align_en(align_en),
        .bitslip(bitslip), .aligned(aligned), .status_req(status_req),
        .status_data(status_data), .status_ack(status_ack)
    );

    always #5 clk_dco_fc = ~clk_dco_fc;

    typedef struct {
        logic [15:0] data;
        logic [15:0] mask;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0]  base;
        bit          rot;
        int          off;
        int          slips;
        logic [15:0] data;
        int          lat;
    } vec_t;
    vec_t vecs[5];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, nslips = 0, last_slip = 0, gap_bad = 0, first_al = -1;
    logic [7:0] base_word = 8'hF0;
    int off = 0;
    bit rot_mode = 1'b0, glitch = 1'b0;
    logic [7:0] glitch_val = 8'h0F;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
        logic [15:0] d;
        d = {w, w} << n;
        return d[15:8];
    endfunction

    task automatic drive_word();
        if (glitch) fco_word = glitch_val;
        else if (rot_mode) fco_word = rotl(base_word, off);
        else fco_word = base_word;
    endtask

    // Advance one clock; the ISERDES model rotates its output on each observed bitslip.
    task automatic tick();
        @(posedge clk_dco_fc);
        #1;
        cyc++;
        if (aligned && first_al < 0) first_al = cyc;
        if (bitslip) begin
            if (nslips > 0 && (cyc - last_slip) < SLIP_WAIT + 1) gap_bad++;
            nslips++;
            last_slip = cyc;
            if (rot_mode && off > 0) off--;
            drive_word();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; align_en = 1'b0; status_ack = 1'b0; glitch = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({bitslip, aligned, status_req, status_data}), 32'h0);
        reset = 1'b0;
        exp_q.delete();
        cyc = 0; nslips = 0; gap_bad = 0; last_slip = 0; first_al = -1;
    endtask

    task automatic wait_req(input int bound, output int waited);
        waited = 0;
        while (!status_req && waited < bound) begin
            tick();
            waited++;
        end
    endtask

    task automatic handshake(input string name);
        int w;
        exp_t e;
        wait_req(300, w);
        check({name, "_req_seen"}, 32'(status_req), 32'h1);
        if (status_req) begin
            check({name, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({name, "_data"}, 32'(status_data & e.mask), 32'(e.data & e.mask));
            end
            status_ack = 1'b1;
            w = 0;
            while (status_req && w < 10) begin
                tick();
                w++;
            end
            n_checks++;
            if (status_req || w < 2 || w > 3) begin
                n_fail++;
                $display("FAIL %s_ack_to_req_fall: got %0d cycles expected 2..3", name, w);
            end
            repeat (3) tick();
            check({name, "_no_req_while_ack"}, 32'(status_req), 32'h0);
            status_ack = 1'b0;
            repeat (3) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        exp_t e;
        vecs[0] = '{8'hF0, 1'b1, 0, 0, 16'hA000, 1 + LOCK_CNT};
        vecs[1] = '{8'hF0, 1'b1, 3, 3, 16'hA180, 1 + 3 * (2 + SLIP_WAIT) + LOCK_CNT};
        vecs[2] = '{8'hF0, 1'b1, 6, 6, 16'hA300, 1 + 6 * (2 + SLIP_WAIT) + LOCK_CNT};
        vecs[3] = '{8'h00, 1'b0, 0, 8, 16'h6C00, 1 + MAX_SLIPS * (2 + SLIP_WAIT) + 1};
        vecs[4] = '{8'hFF, 1'b0, 0, 8, 16'h6C00, 1 + MAX_SLIPS * (2 + SLIP_WAIT) + 1};

        // Alignment from several starting phases and two never-matching words
        for (int i = 0; i < 5; i++) begin
            do_reset();
            base_word = vecs[i].base; rot_mode = vecs[i].rot; off = vecs[i].off;
            drive_word();
            e.data = vecs[i].data; e.mask = 16'hFFFF;
            exp_q.push_back(e);
            align_en = 1'b1;
            wait_req(300, w);
            check($sformatf("v%0d_req_latency", i), 32'(w), 32'(vecs[i].lat + 1));
            if (vecs[i].data[15]) check($sformatf("v%0d_aligned_cycle", i), 32'(first_al), 32'(vecs[i].lat));
            handshake($sformatf("v%0d", i));
            check($sformatf("v%0d_slips", i), 32'(nslips), 32'(vecs[i].slips));
            check($sformatf("v%0d_slip_gap", i), 32'(gap_bad), 32'h0);
            repeat (20) tick();
            check($sformatf("v%0d_no_extra_req", i), 32'(status_req), 32'h0);
            if (!vecs[i].data[15]) begin
                align_en = 1'b0;
                tick();
                repeat (20) tick();
                check($sformatf("v%0d_idle_quiet", i), 32'({aligned, status_req}), 32'h0);
                check($sformatf("v%0d_idle_no_slip", i), 32'(nslips), 32'(vecs[i].slips));
            end
        end

        // Short glitches while locked
        do_reset();
        base_word = 8'hF0; rot_mode = 1'b0; drive_word();
        e.data = 16'hA000; e.mask = 16'hFFFF; exp_q.push_back(e);
        align_en = 1'b1;
        handshake("t4_lock");
`ifndef FCO_LOSS_FILTER_EN
        e.data = 16'h0801; e.mask = 16'hFFFF; exp_q.push_back(e);
        e.data = 16'hA001; exp_q.push_back(e);
`endif
        glitch = 1'b1; glitch_val = 8'h0F; drive_word();
        tick();
        glitch = 1'b0; drive_word();
`ifdef FCO_LOSS_FILTER_EN
        check("t4_glitch1_aligned", 32'(aligned), 32'h1);
        repeat (20) tick();
        check("t4_glitch1_no_req", 32'(status_req), 32'h0);
        check("t4_glitch1_still_aligned", 32'(aligned), 32'h1);
        e.data = 16'h0001; e.mask = 16'h807F; exp_q.push_back(e);
        e.data = 16'hA001; e.mask = 16'hFFFF; exp_q.push_back(e);
`else
        check("t4_glitch1_aligned", 32'(aligned), 32'h0);
        handshake("t4_loss1");
        handshake("t4_relock1");
        e.data = 16'h0002; e.mask = 16'h807F; exp_q.push_back(e);
        e.data = 16'hA082; e.mask = 16'hFFFF; exp_q.push_back(e);
`endif
        glitch = 1'b1; drive_word();
        repeat (2) tick();
        glitch = 1'b0; drive_word();
        check("t4_glitch2_aligned", 32'(aligned), 32'h0);
        handshake("t4_loss2");
        handshake("t4_relock2");
        check("t4_final_aligned", 32'(aligned), 32'h1);

        // Coalescing: three losses while the first transfer is never acknowledged
        do_reset();
        base_word = 8'hF0; rot_mode = 1'b0; drive_word();
        e.data = 16'hA000; e.mask = 16'hFFFF; exp_q.push_back(e);
        align_en = 1'b1;
        wait_req(100, w);
        check("t5_first_req", 32'(status_req), 32'h1);
        for (int k = 0; k < 3; k++) begin
            glitch = 1'b1; drive_word();
            repeat (GLEN) tick();
            glitch = 1'b0; drive_word();
            repeat (LOCK_CNT + 6) tick();
            check($sformatf("t5_req_held_%0d", k), 32'({status_req, status_data}), 32'h1A000);
        end
        e.data = 16'hA003; e.mask = 16'hFFFF; exp_q.push_back(e);
        handshake("t5_first");
        handshake("t5_coalesced");
        repeat (30) tick();
        check("t5_single_followup", 32'(status_req), 32'h0);

        // Reset in the middle of a handshake, then realign
        do_reset();
        base_word = 8'hF0; rot_mode = 1'b0; drive_word();
        align_en = 1'b1;
        wait_req(100, w);
        check("t6_pre_state", 32'({status_req, aligned}), 32'h3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_reset", 32'({bitslip, aligned, status_req, status_data}), 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        cyc = 0; first_al = -1; exp_q.delete();
        e.data = 16'hA000; e.mask = 16'hFFFF; exp_q.push_back(e);
        wait_req(100, w);
        check("t6_relock_cycle", 32'(first_al), 32'(1 + LOCK_CNT));
        handshake("t6_relock");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
